// File: rtl/msram_burst_ctrl_if.sv
// Requester-side handshake for msram_burst_ctrl: burst request, write beat
// stream, read beat stream and completion pulse.
interface msram_burst_ctrl_if #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 16,
    parameter int BL_WIDTH = 4
);
    logic                req;
    logic                req_we;
    logic [A_WIDTH-1:0]  req_addr;
    logic [BL_WIDTH-1:0] burst_len;
    logic [1:0]          req_be_L;
    logic                ready;
    logic                wr_beat_req;
    logic [D_WIDTH-1:0]  wr_data;
    logic                rd_valid;
    logic [D_WIDTH-1:0]  rd_data;
    logic                done;

    modport master (
        output req, req_we, req_addr, burst_len, req_be_L, wr_data,
        input  ready, wr_beat_req, rd_valid, rd_data, done
    );

    modport slave (
        input  req, req_we, req_addr, burst_len, req_be_L, wr_data,
        output ready, wr_beat_req, rd_valid, rd_data, done
    );
endinterface

// File: rtl/msram_burst_ctrl.sv
// Burst controller for the MT45W8 pseudo-SRAM in fixed-latency burst mode.
// Sequence per burst: IDLE -> ADDR -> WAIT (LATENCY-1) -> DATA (len) -> RECOVER.
// All SRAM pins and read data come straight from flops; the data bus is only
// driven from the registered write beat and drive enable.
// Optional feature macro: MSRAM_BYTE_EN_EN (latched req_be_L drives ub_L/lb_L).
module msram_burst_ctrl #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 16,
    parameter int LATENCY  = 4,
    parameter int BL_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_L,
    msram_burst_ctrl_if.slave  bus,
    output logic [A_WIDTH-1:0] sram_addr,
    output logic               sram_adv_L,
    output logic               sram_ce_L,
    output logic               sram_oe_L,
    output logic               sram_we_L,
    output logic               sram_ub_L,
    output logic               sram_lb_L,
    output logic               sram_mcre,
    input  logic               sram_wait,
    inout  wire  [D_WIDTH-1:0] sram_data
);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 2);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA, S_RECOVER} state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_we;
    logic [BL_WIDTH-1:0] r_len;
    logic [BL_WIDTH-1:0] r_beat;
    logic [CW-1:0]       r_cnt;
    logic [A_WIDTH-1:0]  r_addr;
    logic                r_ce_L, r_adv_L, r_oe_L, r_we_L, r_ub_L, r_lb_L;
    logic                r_wr_beat_req;
    logic                r_rd_valid;
    logic [D_WIDTH-1:0]  r_rd_data;
    logic                r_done;
    logic                r_drv;
    logic [D_WIDTH-1:0]  r_wdata;
    logic [1:0]          w_be_L;

`ifdef MSRAM_BYTE_EN_EN
    assign w_be_L = bus.req_be_L;
`else
    // Byte lanes are always both enabled during a burst.
    assign w_be_L = 2'b00;
    wire w_unused_be = &{1'b0, bus.req_be_L};
`endif

    // Fixed-latency mode: the SRAM wait pin carries no information for us.
    wire w_unused_wait = &{1'b0, sram_wait};

    // Burst sequencer; every pin-facing output is registered here.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_we          <= 1'b0;
            r_len         <= '0;
            r_beat        <= '0;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_ce_L        <= 1'b1;
            r_adv_L       <= 1'b1;
            r_oe_L        <= 1'b1;
            r_we_L        <= 1'b1;
            r_ub_L        <= 1'b1;
            r_lb_L        <= 1'b1;
            r_wr_beat_req <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_done        <= 1'b0;
            r_drv         <= 1'b0;
            r_wdata       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req && r_ready) begin
                        r_we             <= bus.req_we;
                        r_len            <= bus.burst_len;
                        r_addr           <= bus.req_addr;
                        r_ready          <= 1'b0;
                        r_ce_L           <= 1'b0;
                        r_adv_L          <= 1'b0;
                        r_we_L           <= ~bus.req_we;
                        {r_ub_L, r_lb_L} <= w_be_L;
                        r_state          <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_adv_L       <= 1'b1;
                    r_oe_L        <= r_we;
                    r_cnt         <= CNT_INIT;
                    // With a single WAIT cycle it is also the last one.
                    r_wr_beat_req <= r_we && (LATENCY == 2);
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DATA;
                        r_beat  <= '0;
                        if (r_we) begin
                            r_wdata <= bus.wr_data;
                            r_drv   <= 1'b1;
                        end
                        r_wr_beat_req <= r_we && (r_len != '0);
                    end else begin
                        r_cnt         <= r_cnt - 1'b1;
                        r_wr_beat_req <= r_we && (r_cnt == CW'(1));
                    end
                end
                S_DATA: begin
                    if (r_we) begin
                        if (r_wr_beat_req) r_wdata <= bus.wr_data;
                    end else begin
                        r_rd_data  <= sram_data;
                        r_rd_valid <= 1'b1;
                    end
                    if (r_beat == r_len) begin
                        r_state       <= S_RECOVER;
                        r_ce_L        <= 1'b1;
                        r_oe_L        <= 1'b1;
                        r_we_L        <= 1'b1;
                        r_ub_L        <= 1'b1;
                        r_lb_L        <= 1'b1;
                        r_drv         <= 1'b0;
                        r_wr_beat_req <= 1'b0;
                        r_done        <= 1'b1;
                    end else begin
                        r_beat        <= r_beat + 1'b1;
                        // Ask for another beat only while one is still to come.
                        r_wr_beat_req <= r_we && ((r_beat + 1'b1) < r_len);
                    end
                end
                S_RECOVER: begin
                    r_rd_valid <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_data       = r_drv ? r_wdata : {D_WIDTH{1'bz}};
    assign sram_addr       = r_addr;
    assign sram_adv_L      = r_adv_L;
    assign sram_ce_L       = r_ce_L;
    assign sram_oe_L       = r_oe_L;
    assign sram_we_L       = r_we_L;
    assign sram_ub_L       = r_ub_L;
    assign sram_lb_L       = r_lb_L;
    assign sram_mcre       = 1'b0;
    assign bus.ready       = r_ready;
    assign bus.wr_beat_req = r_wr_beat_req;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_data     = r_rd_data;
    assign bus.done        = r_done;
endmodule

// File: doc/msram_burst_ctrl.md
Name: msram_burst_ctrl

Overview:
Controller that sequences the MT45W8 pseudo-SRAM in burst, fixed-latency mode for a single on-chip requester. It accepts one read or write burst request at a time and drives the SRAM pins: addr, adv_L, ce_L, oe_L, we_L, ub_L, lb_L, mcre and the bidirectional data bus. It streams write beats in and read beats out. It sits between the system bus master and the external or modelled pseudo-SRAM.

Parameters:
D_WIDTH, 16, data bus width.
A_WIDTH, 16, SRAM word-address width.
LATENCY, 4, SRAM fixed latency in clocks; the WAIT phase lasts LATENCY-1 cycles.
BL_WIDTH, 4, burst_len width; burst length = burst_len+1, giving 1..16 beats.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_L  in  1  asynchronous active-low reset.
req  in  1  burst request, qualified by ready.
req_we  in  1  1=write burst, 0=read burst.
req_addr  in  A_WIDTH  first word address.
burst_len  in  BL_WIDTH  beats minus one.
req_be_L  in  2  byte enables {ub,lb}, active low; used only with MSRAM_BYTE_EN_EN.
ready  out  1  controller idle; request accepted on posedge when req&ready.
wr_beat_req  out  1  requester must present the next write beat on wr_data this cycle.
wr_data  in  D_WIDTH  write beat, sampled on posedge while wr_beat_req=1.
rd_valid  out  1  rd_data holds a read beat.
rd_data  out  D_WIDTH  registered read beat.
done  out  1  one-cycle pulse at burst completion.
sram_addr  out  A_WIDTH  SRAM address.
sram_adv_L  out  1  address valid.
sram_ce_L  out  1  chip enable.
sram_oe_L  out  1  output enable.
sram_we_L  out  1  write enable.
sram_ub_L  out  1  upper byte enable.
sram_lb_L  out  1  lower byte enable.
sram_mcre  out  1  config-register enable; tied 0.
sram_wait  in  1  SRAM wait; ignored; fixed latency only.
sram_data  inout  D_WIDTH  SRAM data bus.

Behaviour:
- All SRAM control outputs and rd_data come from registers. The data bus is driven only from the registered write-data and drive-enable flops.
- Reset (asynchronous, while rst_L=0): state=IDLE, ready=1, ce_L/adv_L/oe_L/we_L/ub_L/lb_L=1, mcre=0, sram_addr=0, rd_valid=0, rd_data=0, wr_beat_req=0, done=0, data bus hi-Z.
- Reset asserted mid-burst aborts the burst immediately. Nothing else completes; no done pulse.
- States: IDLE -> ADDR -> WAIT -> DATA -> RECOVER -> IDLE.
- IDLE: ready=1. On req&ready, latch addr, we, len and be, then go to ADDR. Requests while ready=0 are ignored.
- ADDR (1 cycle): ce_L=0, adv_L=0, we_L=latched we inverted, sram_addr=latched address.
- WAIT (LATENCY-1 cycles, counted by a down-counter): ce_L=0, adv_L=1.
  - For reads, oe_L=0.
  - For writes, wr_beat_req=1 in the last WAIT cycle only.
  - we_L stays at its ADDR value; sram_addr holds.
- DATA (len cycles, beat counter 0..len-1): ce_L=0.
  - Write: sram_data drives the beat registered from wr_data. wr_beat_req=1 on beats 0..len-2.
  - Read: sram_data is hi-Z and oe_L=0. rd_data is captured on each DATA posedge, so rd_valid=1 for exactly len cycles, starting the cycle after the first DATA cycle.
- RECOVER (1 cycle): ce_L=1, oe_L=1, we_L=1, bus hi-Z, done=1. The last read beat is valid this cycle. Next cycle goes to IDLE with ready=1.
- Request-to-ADDR latency is 1 clock. Minimum gap between back-to-back bursts is the RECOVER and IDLE cycles.
- The controller does not increment addresses; the SRAM does. A burst crossing the top address wraps to 0 in the SRAM. The controller takes no action on wrap.
- Bus turnaround: the controller never drives sram_data in a cycle where oe_L=0.

Optional Feature:
MSRAM_BYTE_EN_EN
- Defined: req_be_L is latched at acceptance and drives ub_L/lb_L from ADDR through DATA. Both byte enables are 1 in IDLE and RECOVER.
- Undefined: req_be_L is ignored. ub_L=lb_L=0 from ADDR through DATA, and 1 otherwise.

Test Plan:
- Write, addr 0x0010, burst_len=3, beats A000..A003 -> ADDR 1 cycle after accept; 3 WAIT cycles; 4 DATA cycles; memory 0x10..0x13 = A000..A003; done pulses once.
- Read back same burst -> rd_valid high 4 consecutive cycles starting at DATA+1, rd_data = A000..A003; oe_L=0 across WAIT and DATA; controller never drives the bus.
- Write then read at addr 0xFFFE, burst_len=3 -> words land at 0xFFFE, 0xFFFF, 0x0000, 0x0001; readback matches.
- burst_len=0 write of 0x1234 to 0x0005 followed immediately by a read request held high -> single DATA beat; read accepted only when ready returns; readback 0x1234.
- rst_L pulsed low during DATA beat 2 of a write -> outputs take reset values asynchronously, no done pulse; ready=1 the cycle after release.
- With MSRAM_BYTE_EN_EN, write 0xBEEF with req_be_L=2'b10 over 0x0000 -> lb_L=0 and ub_L=1 during the burst. Without the macro, both stay 0 during the burst.
